// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues word addresses into a partitioned instruction
// memory, tracks the one fetch in flight and registers the returned word for decode.
module fetch_unit #(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 11,
    parameter int PARTITION_WIDTH = 9
) (
    input  logic                                  i_clock,
    input  logic                                  i_reset_n,
    input  logic                                  i_stall,
    input  logic                                  i_branch_taken,
    input  logic [PARTITION_WIDTH-1:0]            i_branch_target,
    input  logic                                  i_jump,
    input  logic [PARTITION_WIDTH-1:0]            i_jump_target,
    input  logic                                  i_switch_req,
    input  logic [ADDR_WIDTH-PARTITION_WIDTH-1:0] i_switch_partition,
    input  logic [PARTITION_WIDTH-1:0]            i_switch_offset,
    input  logic [DATA_WIDTH-1:0]                 i_memory_instruction,
    output logic [DATA_WIDTH-1:0]                 o_address,
    output logic [DATA_WIDTH-1:0]                 o_instruction,
    output logic [ADDR_WIDTH-1:0]                 o_instruction_pc,
    output logic                                  o_instruction_valid,
    output logic [ADDR_WIDTH-PARTITION_WIDTH-1:0] o_partition
);

    localparam int SEL_WIDTH = ADDR_WIDTH - PARTITION_WIDTH;
    localparam logic [PARTITION_WIDTH-1:0] OFFSET_ONE = PARTITION_WIDTH'(1);

    logic [PARTITION_WIDTH-1:0] r_pc;
    logic [PARTITION_WIDTH-1:0] r_pending_pc;
    logic                       r_pending_valid;
    logic [SEL_WIDTH-1:0]       r_partition;
    logic [DATA_WIDTH-1:0]      r_instruction;
    logic [ADDR_WIDTH-1:0]      r_instruction_pc;
    logic                       r_instruction_valid;

    logic                       w_redirect;
    logic [PARTITION_WIDTH-1:0] w_target;
    logic [SEL_WIDTH-1:0]       w_issue_partition;
    logic [PARTITION_WIDTH-1:0] w_issue_offset;
    logic [PARTITION_WIDTH-1:0] w_issue_next;
    logic [ADDR_WIDTH-1:0]      w_issue_addr;

    assign w_redirect = i_switch_req | i_jump | i_branch_taken;

    // Redirect priority: partition switch, then jump, then branch.
    always_comb begin
        w_target = i_branch_target;
        if (i_switch_req) begin
            w_target = i_switch_offset;
        end else if (i_jump) begin
            w_target = i_jump_target;
        end
    end

    // While stalled the pending word is re-presented so memory returns it again on release.
    always_comb begin
        w_issue_partition = r_partition;
        w_issue_offset    = r_pc;
        if (i_stall) begin
            w_issue_offset = r_pending_pc;
        end else if (w_redirect) begin
            w_issue_offset = w_target;
            if (i_switch_req) begin
                w_issue_partition = i_switch_partition;
            end
        end
    end

    // Offset arithmetic stays inside the partition: 511 + 1 wraps to 0.
    assign w_issue_next = w_issue_offset + OFFSET_ONE;
    assign w_issue_addr = {w_issue_partition, w_issue_offset};

    assign o_address = i_reset_n ? {{(DATA_WIDTH-ADDR_WIDTH){1'b0}}, w_issue_addr}
                                 : '0;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_pc                <= '0;
            r_pending_pc        <= '0;
            r_pending_valid     <= 1'b0;
            r_partition         <= '0;
            r_instruction       <= '0;
            r_instruction_pc    <= '0;
            r_instruction_valid <= 1'b0;
        end else if (!i_stall) begin
            r_pc                <= w_issue_next;
            r_pending_pc        <= w_issue_offset;
            r_pending_valid     <= 1'b1;
            r_partition         <= w_issue_partition;
            r_instruction       <= i_memory_instruction;
            r_instruction_pc    <= {r_partition, r_pending_pc};
            // A redirect squashes the sequential word arriving this cycle.
            r_instruction_valid <= r_pending_valid & ~w_redirect;
        end
    end

    assign o_instruction       = r_instruction;
    assign o_instruction_pc    = r_instruction_pc;
    assign o_instruction_valid = r_instruction_valid;
    assign o_partition         = r_partition;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: queue-based fetch model compared every cycle, plus
// directed scenarios with hand-computed expectations.
module tb_fetch_unit;

    localparam int DW = 32;
    localparam int AW = 11;
    localparam int PW = 9;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          stall = 1'b0;
    logic          br = 1'b0;
    logic [PW-1:0] br_t = '0;
    logic          jmp = 1'b0;
    logic [PW-1:0] jmp_t = '0;
    logic          sw = 1'b0;
    logic [1:0]    sw_p = '0;
    logic [PW-1:0] sw_off = '0;
    logic [DW-1:0] mem_q = '0;

    logic [DW-1:0] o_address;
    logic [DW-1:0] o_instruction;
    logic [AW-1:0] o_instruction_pc;
    logic          o_instruction_valid;
    logic [1:0]    o_partition;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_unit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PARTITION_WIDTH(PW)) dut (
        .i_clock             (clk),
        .i_reset_n           (rst_n),
        .i_stall             (stall),
        .i_branch_taken      (br),
        .i_branch_target     (br_t),
        .i_jump              (jmp),
        .i_jump_target       (jmp_t),
        .i_switch_req        (sw),
        .i_switch_partition  (sw_p),
        .i_switch_offset     (sw_off),
        .i_memory_instruction(mem_q),
        .o_address           (o_address),
        .o_instruction       (o_instruction),
        .o_instruction_pc    (o_instruction_pc),
        .o_instruction_valid (o_instruction_valid),
        .o_partition         (o_partition)
    );

    function automatic logic [DW-1:0] word(input logic [AW-1:0] a);
        return 32'h5A00_0000 | {21'd0, a};
    endfunction

    // Instruction memory with one cycle read latency.
    always @(posedge clk) mem_q <= word(o_address[AW-1:0]);

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a queue of issued full addresses; each unstalled edge delivers the
    // oldest issued word unless a redirect flushes it, then issues one more.
    logic [1:0]    m_part = '0;
    logic [PW-1:0] m_next = '0;
    logic [AW-1:0] m_q[$];
    logic          m_vld = 1'b0;
    logic [AW-1:0] m_pc = '0;
    logic [AW-1:0] m_issue;

    always begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_part = '0;
            m_next = '0;
            m_q.delete();
            m_vld  = 1'b0;
            m_pc   = '0;
        end else if (!stall) begin
            if (sw || jmp || br) begin
                m_vld = 1'b0;
                m_q.delete();
                if (sw) begin
                    m_part  = sw_p;
                    m_issue = {sw_p, sw_off};
                end else if (jmp) begin
                    m_issue = {m_part, jmp_t};
                end else begin
                    m_issue = {m_part, br_t};
                end
                m_next = m_issue[PW-1:0] + 9'd1;
            end else begin
                if (m_q.size() > 0) begin
                    m_pc  = m_q.pop_front();
                    m_vld = 1'b1;
                end else begin
                    m_vld = 1'b0;
                end
                m_issue = {m_part, m_next};
                m_next  = m_next + 9'd1;
            end
            m_q.push_back(m_issue);
        end
    end

    function automatic logic [DW-1:0] exp_address();
        logic [AW-1:0] a;
        if (!rst_n) return '0;
        if (stall) a = (m_q.size() > 0) ? m_q[0] : '0;
        else if (sw) a = {sw_p, sw_off};
        else if (jmp) a = {m_part, jmp_t};
        else if (br) a = {m_part, br_t};
        else a = {m_part, m_next};
        return {21'd0, a};
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            #3;
            chk("valid", {31'd0, o_instruction_valid}, {31'd0, m_vld});
            chk("partition", {30'd0, o_partition}, {30'd0, m_part});
            chk("address", o_address, exp_address());
            if (!rst_n) begin
                chk("rst_instr", o_instruction, '0);
                chk("rst_pc", {21'd0, o_instruction_pc}, '0);
            end else if (m_vld) begin
                chk("pc", {21'd0, o_instruction_pc}, {21'd0, m_pc});
                chk("instr", o_instruction, word(m_pc));
            end
        end
    end

    task automatic wait_pc(input logic [AW-1:0] p, input int budget);
        int n = 0;
        while (!(m_vld && m_pc == p) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            checks++;
            errors++;
            $display("FAIL wait_pc: pc %0d not seen within %0d cycles", p, budget);
        end
    endtask

    initial begin
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        chk("lit_rst_valid", {31'd0, o_instruction_valid}, 32'd0);
        chk("lit_rst_addr", o_address, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #2;
        chk("lit_edge1_valid", {31'd0, o_instruction_valid}, 32'd0);
        chk("lit_edge1_addr", o_address, 32'd1);
        @(posedge clk); #2;
        chk("lit_edge2_valid", {31'd0, o_instruction_valid}, 32'd1);
        chk("lit_edge2_pc", {21'd0, o_instruction_pc}, 32'd0);
        chk("lit_edge2_instr", o_instruction, 32'h5A00_0000);
        @(posedge clk); #2;
        chk("lit_edge3_instr", o_instruction, 32'h5A00_0001);

        // Offset wrap within partition 0.
        wait_pc(11'd511, 600);
        @(posedge clk); #2;
        chk("lit_wrap_pc", {21'd0, o_instruction_pc}, 32'd0);
        chk("lit_wrap_part", {30'd0, o_partition}, 32'd0);

        // Branch, then branch+jump together.
        wait_pc(11'd10, 40);
        br = 1'b1; br_t = 9'd100;
        @(negedge clk); br = 1'b0; #1;
        chk("lit_br_bubble", {31'd0, o_instruction_valid}, 32'd0);
        @(negedge clk); #1;
        chk("lit_br_pc", {21'd0, o_instruction_pc}, 32'd100);
        wait_pc(11'd103, 20);
        br = 1'b1; br_t = 9'd50; jmp = 1'b1; jmp_t = 9'd200;
        @(negedge clk); br = 1'b0; jmp = 1'b0; #1;
        chk("lit_jmp_bubble", {31'd0, o_instruction_valid}, 32'd0);
        @(negedge clk); #1;
        chk("lit_jmp_pc", {21'd0, o_instruction_pc}, 32'd200);

        // Three stalled edges with an ignored branch.
        wait_pc(11'd205, 20);
        stall = 1'b1; br = 1'b1; br_t = 9'd7;
        #1 chk("lit_stall_addr", o_address, 32'd206);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk("lit_stall_pc", {21'd0, o_instruction_pc}, 32'd205);
            chk("lit_stall_hold_addr", o_address, 32'd206);
        end
        stall = 1'b0; br = 1'b0;
        @(negedge clk); #1;
        chk("lit_release_pc", {21'd0, o_instruction_pc}, 32'd206);
        @(negedge clk); #1;
        chk("lit_release_pc2", {21'd0, o_instruction_pc}, 32'd207);

        // Partition switch with a simultaneous branch.
        sw = 1'b1; sw_p = 2'd2; sw_off = 9'd5; br = 1'b1; br_t = 9'd9;
        #1 chk("lit_sw_addr", o_address, 32'd1029);
        @(negedge clk); sw = 1'b0; br = 1'b0; #1;
        chk("lit_sw_part", {30'd0, o_partition}, 32'd2);
        chk("lit_sw_bubble", {31'd0, o_instruction_valid}, 32'd0);
        @(negedge clk); #1;
        chk("lit_sw_pc", {21'd0, o_instruction_pc}, 32'd1029);
        chk("lit_sw_instr", o_instruction, 32'h5A00_0405);
        @(negedge clk); #1;
        chk("lit_sw_pc2", {21'd0, o_instruction_pc}, 32'd1030);

        // Short reset pulse during a jump.
        @(negedge clk);
        jmp = 1'b1; jmp_t = 9'd300;
        #1 rst_n = 1'b0;
        #1;
        chk("lit_pulse_addr", o_address, 32'd0);
        chk("lit_pulse_valid", {31'd0, o_instruction_valid}, 32'd0);
        chk("lit_pulse_part", {30'd0, o_partition}, 32'd0);
        chk("lit_pulse_instr", o_instruction, 32'd0);
        #2 rst_n = 1'b1; jmp = 1'b0;
        @(negedge clk); #1;
        chk("lit_restart_valid0", {31'd0, o_instruction_valid}, 32'd0);
        chk("lit_restart_addr", o_address, 32'd1);
        @(negedge clk); #1;
        chk("lit_restart_valid1", {31'd0, o_instruction_valid}, 32'd1);
        chk("lit_restart_pc", {21'd0, o_instruction_pc}, 32'd0);
        repeat (5) @(negedge clk);
        #4;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
